// File: rtl/audio_stream_player.sv
// audio_stream_player: sample buffer with prebuffered stream playback, tone and mute generation
// Ports:
//   i_clk               system clock
//   i_reset             synchronous active-high reset
//   i_mode              00 mute, 01 stream, 10 tone, 11 mute
//   i_tone_half_period  tone half period in sample ticks, 0 = constant midscale
//   i_wr_data/i_wr_valid/o_wr_ready  sample write handshake into the buffer
//   o_sample_out        current output sample
//   o_sample_strobe     one-cycle pulse when o_sample_out updates
//   o_level             entries currently buffered
//   o_playing           stream engine is playing from the buffer
//   o_underrun_count    saturating count of underruns since reset
module audio_stream_player #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 2048,
    parameter int SAMPLE_DIV  = 2083,
    parameter int START_LEVEL = 512
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [1:0]               i_mode,
    input  logic [15:0]              i_tone_half_period,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_wr_valid,
    output logic                     o_wr_ready,
    output logic [DATA_W-1:0]        o_sample_out,
    output logic                     o_sample_strobe,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_playing,
    output logic [15:0]              o_underrun_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(SAMPLE_DIV);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PLAY = 1'b1;
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic [TW-1:0]     r_tick_cnt;
    logic [0:0]        r_state;
    logic [15:0]       r_tone_cnt;
    logic              r_tone_ph;
    logic              r_s1_valid;
    logic              r_s1_pop;
    logic [DATA_W-1:0] r_s1_val;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_sample_out;
    logic              r_strobe;
    logic [15:0]       r_underrun;

    logic              w_tick;
    logic              w_stream;
    logic              w_push;
    logic              w_pop;
    logic              w_underrun;
    logic              w_tone_on;
    logic [DATA_W-1:0] w_gen_val;

    assign w_tick     = r_tick_cnt == TW'(SAMPLE_DIV - 1);
    assign w_stream   = i_mode == 2'b01;
    assign o_wr_ready = (r_level != (AW+1)'(DEPTH)) && !i_reset;
    assign w_push     = i_wr_valid && o_wr_ready;
    assign w_pop      = w_tick && w_stream && r_state == S_PLAY && r_level != '0;
    assign w_underrun = w_tick && w_stream && r_state == S_PLAY && r_level == '0;
    assign w_tone_on  = i_mode == 2'b10 && i_tone_half_period != 16'd0;
    // Non-popping ticks emit midscale except an active tone
    assign w_gen_val  = w_tone_on ? (r_tone_ph ? '1 : '0) : MID;

    assign o_sample_out     = r_sample_out;
    assign o_sample_strobe  = r_strobe;
    assign o_level          = r_level;
    assign o_playing        = r_state == S_PLAY;
    assign o_underrun_count = r_underrun;

    // Buffer RAM: registered read gives the first latency stage for popped samples
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
        r_rd_data <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_tick_cnt   <= '0;
            r_state      <= S_IDLE;
            r_tone_cnt   <= '0;
            r_tone_ph    <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_pop     <= 1'b0;
            r_s1_val     <= MID;
            r_sample_out <= MID;
            r_strobe     <= 1'b0;
            r_underrun   <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level    <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_s1_valid <= w_tick;
            r_s1_pop   <= w_pop;
            r_s1_val   <= w_gen_val;
            r_strobe   <= r_s1_valid;
            if (r_s1_valid) r_sample_out <= r_s1_pop ? r_rd_data : r_s1_val;
            if (w_underrun && r_underrun != 16'hFFFF) r_underrun <= r_underrun + 16'd1;
            r_state <= !w_stream ? S_IDLE :
                       (r_state == S_IDLE && r_level >= (AW+1)'(START_LEVEL)) ? S_PLAY :
                       w_underrun ? S_IDLE : r_state;
            // Tone phase shown on a tick is the phase before that tick's update
            if (w_tick && i_mode == 2'b10) begin
                r_tone_cnt <= (i_tone_half_period == 16'd0 ||
                               r_tone_cnt == i_tone_half_period - 16'd1) ? 16'd0 : r_tone_cnt + 16'd1;
                r_tone_ph  <= (i_tone_half_period != 16'd0 &&
                               r_tone_cnt == i_tone_half_period - 16'd1) ? !r_tone_ph : r_tone_ph;
            end
        end
    end
endmodule
